// File: rtl/serial_01_tx.sv
// Serial transmitter: shifts a WIDTH-bit word out MSB first and counts emitted "01" pairs.
// Optional even-parity trailer bit enabled by defining SERIAL_01_TX_PARITY_EN.
module serial_01_tx #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             last,
    output logic             done,
    output logic [CW-1:0]    cnt01
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

`ifdef SERIAL_01_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sreg_reg, sreg_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic             prev_reg, prev_next;
    logic             ready_reg, ready_next;
    logic             bit_out_reg, bit_out_next;
    logic             bit_valid_reg, bit_valid_next;
    logic             last_reg, last_next;
    logic             done_reg, done_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
`ifdef SERIAL_01_TX_PARITY_EN
    logic             par_reg, par_next;
`endif
    logic             start;

    assign ready     = ready_reg;
    assign bit_out   = bit_out_reg;
    assign bit_valid = bit_valid_reg;
    assign last      = last_reg;
    assign done      = done_reg;
    assign cnt01     = cnt_reg;

    // A frame may start from IDLE or directly out of DONE (one-cycle gap).
    assign start = load && ((state_reg == IDLE) || (state_reg == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sreg_reg      <= '0;
            idx_reg       <= '0;
            prev_reg      <= 1'b1;
            ready_reg     <= 1'b1;
            bit_out_reg   <= 1'b0;
            bit_valid_reg <= 1'b0;
            last_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cnt_reg       <= '0;
`ifdef SERIAL_01_TX_PARITY_EN
            par_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            sreg_reg      <= sreg_next;
            idx_reg       <= idx_next;
            prev_reg      <= prev_next;
            ready_reg     <= ready_next;
            bit_out_reg   <= bit_out_next;
            bit_valid_reg <= bit_valid_next;
            last_reg      <= last_next;
            done_reg      <= done_next;
            cnt_reg       <= cnt_next;
`ifdef SERIAL_01_TX_PARITY_EN
            par_reg       <= par_next;
`endif
        end
    end

    // Outputs are registered: each branch computes what is visible in the next cycle.
    always_comb begin
        state_next     = state_reg;
        sreg_next      = sreg_reg;
        idx_next       = idx_reg;
        prev_next      = prev_reg;
        ready_next     = ready_reg;
        bit_out_next   = bit_out_reg;
        bit_valid_next = bit_valid_reg;
        last_next      = last_reg;
        done_next      = done_reg;
        cnt_next       = cnt_reg;
`ifdef SERIAL_01_TX_PARITY_EN
        par_next       = par_reg;
`endif

        case (state_reg)
            IDLE: begin
                done_next = 1'b0;
            end
            SHIFT: begin
                if (idx_reg == LAST_IDX) begin
`ifdef SERIAL_01_TX_PARITY_EN
                    state_next   = PAR;
                    bit_out_next = par_reg;
                    last_next    = 1'b1;
`else
                    state_next     = DONE;
                    bit_valid_next = 1'b0;
                    bit_out_next   = 1'b0;
                    last_next      = 1'b0;
                    done_next      = 1'b1;
                    ready_next     = 1'b1;
`endif
                end else begin
                    bit_out_next = sreg_reg[WIDTH-1];
                    sreg_next    = sreg_reg << 1;
                    idx_next     = IW'(idx_reg + 1'b1);
`ifdef SERIAL_01_TX_PARITY_EN
                    last_next    = 1'b0;
`else
                    last_next    = (IW'(idx_reg + 1'b1) == LAST_IDX);
`endif
                    if (!prev_reg && sreg_reg[WIDTH-1] && (cnt_reg != {CW{1'b1}}))
                        cnt_next = cnt_reg + 1'b1;
                    prev_next = sreg_reg[WIDTH-1];
                end
            end
`ifdef SERIAL_01_TX_PARITY_EN
            PAR: begin
                state_next     = DONE;
                bit_valid_next = 1'b0;
                bit_out_next   = 1'b0;
                last_next      = 1'b0;
                done_next      = 1'b1;
                ready_next     = 1'b1;
            end
`endif
            DONE: begin
                state_next = IDLE;
                done_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // First bit goes out immediately; prev is then that bit, so it cannot close a pair.
        if (start) begin
            state_next     = SHIFT;
            ready_next     = 1'b0;
            done_next      = 1'b0;
            bit_valid_next = 1'b1;
            bit_out_next   = din[WIDTH-1];
            sreg_next      = din << 1;
            idx_next       = '0;
            last_next      = 1'b0;
            cnt_next       = '0;
            prev_next      = din[WIDTH-1];
`ifdef SERIAL_01_TX_PARITY_EN
            par_next       = ^din;
`endif
        end
    end

endmodule

// File: tb/tb_serial_01_tx.sv
// Bench for serial_01_tx: cycle-accurate scoreboard plus a table of frames and directed corner cases.
module tb_serial_01_tx;
    localparam int WIDTH = 8;
    localparam int CW    = 4;
`ifdef SERIAL_01_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = WIDTH + PAR;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             ready, bit_out, bit_valid, last, done;
    logic [CW-1:0]    cnt01;

    always #5 clk = ~clk;

    serial_01_tx #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .load(load), .din(din), .ready(ready),
        .bit_out(bit_out), .bit_valid(bit_valid), .last(last), .done(done), .cnt01(cnt01)
    );

    typedef struct packed {
        logic          valid;
        logic          bitv;
        logic          lst;
        logic          dn;
        logic          rdy;
        logic [CW-1:0] cnt;
    } obs_t;

    typedef struct {
        logic [WIDTH-1:0] din;
        int               cnt;
        logic             par;
    } vec_t;

    obs_t          exp_q[$];
    logic [CW-1:0] hold_cnt = '0;
    bit            model_ready = 1'b1;
    int            busy = 0;
    bit            mon_en = 1'b0;
    int            n_cmp = 0;
    int            n_err = 0;
    vec_t          vt[10];

    // Expected per-cycle outputs for one accepted frame.
    function automatic void push_frame(input logic [WIDTH-1:0] d);
        logic          prev = 1'b1;
        logic [CW-1:0] c = '0;
        logic          b;
        for (int k = 0; k < WIDTH; k++) begin
            b = d[WIDTH-1-k];
            if (!prev && b && (c != {CW{1'b1}})) c = c + 1'b1;
            prev = b;
            exp_q.push_back('{1'b1, b, (k == WIDTH-1) && (PAR == 0), 1'b0, 1'b0, c});
        end
        if (PAR == 1) exp_q.push_back('{1'b1, ^d, 1'b1, 1'b0, 1'b0, c});
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, c});
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Acceptance model: decides when a load is taken, independent of the DUT.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            hold_cnt    = '0;
            model_ready = 1'b1;
            busy        = 0;
        end else if (!model_ready) begin
            busy--;
            if (busy == 0) model_ready = 1'b1;
        end else if (load) begin
            push_frame(din);
            model_ready = 1'b0;
            busy        = FL;
        end
    end

    // Scoreboard monitor: one comparison of all outputs per cycle.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, hold_cnt};
                if (e.dn) hold_cnt = e.cnt;
                a = {bit_valid, bit_out, last, done, ready, cnt01};
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL outputs t=%0t: got v%b b%b l%b d%b r%b c%0d, expected v%b b%b l%b d%b r%b c%0d",
                             $time, a.valid, a.bitv, a.lst, a.dn, a.rdy, a.cnt,
                             e.valid, e.bitv, e.lst, e.dn, e.rdy, e.cnt);
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", ready, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int   t = 0;
        logic exp_last;
        @(negedge clk);
        wait_ready();
        load = 1'b1;
        din  = v.din;
        @(negedge clk);
        load = 1'b0;
        din  = WIDTH'($urandom);
        while (!last && t < 40) begin
            @(negedge clk);
            t++;
        end
        exp_last = (PAR == 1) ? v.par : v.din[0];
        check("last_seen", last, 1);
        check("last_cycle", t, FL - 1);
        check("last_bit", bit_out, exp_last);
        @(negedge clk);
        check("done_after_last", done, 1);
        check("cnt01_final", cnt01, v.cnt);
        $display("frame din=%b cnt01=%0d last_bit=%b", v.din, cnt01, exp_last);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        int seen;
        int last_done;
        vt[0] = '{8'b01010101, 4, 1'b0};
        vt[1] = '{8'hFF,       0, 1'b0};
        vt[2] = '{8'b00001111, 1, 1'b0};
        vt[3] = '{8'b10000001, 1, 1'b0};
        vt[4] = '{8'h00,       0, 1'b0};
        vt[5] = '{8'b10101010, 3, 1'b0};
        vt[6] = '{8'b00000001, 1, 1'b1};
        vt[7] = '{8'b01100110, 2, 1'b0};
        vt[8] = '{8'b00000111, 1, 1'b1};
        vt[9] = '{8'b10000000, 0, 1'b1};

        rst  = 1'b1;
        load = 1'b0;
        din  = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_ready", ready, 1);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_done", done, 0);
        check("rst_cnt01", cnt01, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vt[i]);

        // load held high: frames separated by exactly one DONE cycle
        @(negedge clk);
        wait_ready();
        load = 1'b1;
        last_done = -1;
        for (int c = 0; c < 4 * (FL + 1); c++) begin
            @(negedge clk);
            din = WIDTH'($urandom);
            if (done) begin
                if (last_done >= 0) check("b2b_period", c - last_done, FL + 1);
                last_done = c;
            end
        end
        load = 1'b0;
        repeat (FL + 2) @(negedge clk);

        // load pulse during SHIFT is ignored
        wait_ready();
        load = 1'b1;
        din  = 8'b01010101;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        load = 1'b1;
        din  = 8'hFF;
        @(negedge clk);
        load = 1'b0;
        seen = 0;
        while (!done && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        check("ignored_load_done", done, 1);
        check("ignored_load_cnt01", cnt01, 4);
        repeat (3) @(negedge clk);

        // reset in cycle 4 of a frame aborts it
        wait_ready();
        load = 1'b1;
        din  = 8'b01010101;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", ready, 1);
        check("abort_bit_valid", bit_valid, 0);
        check("abort_bit_out", bit_out, 0);
        check("abort_last", last, 0);
        check("abort_done", done, 0);
        check("abort_cnt01", cnt01, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < FL + 3; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        run_vec(vt[2]);

        // rst and load together: rst wins
        @(negedge clk);
        wait_ready();
        rst  = 1'b1;
        load = 1'b1;
        din  = 8'b01010101;
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        check("rst_beats_load_valid", bit_valid, 0);
        check("rst_beats_load_ready", ready, 1);
        run_vec(vt[0]);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
